// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: decode-source hazard checks
// and HI/LO unit occupancy. Optional perf counters under HAZARD_PERF_EN.

module hazard_src_chk (
    input  logic [4:0] src,
    input  logic [1:0] tuse,
    input  logic [4:0] e_a3,
    input  logic [1:0] e_tnew,
    input  logic [4:0] m_a3,
    input  logic [1:0] m_tnew,
    output logic       hazard
);
    logic e_hit;
    logic m_hit;

    assign e_hit  = (src == e_a3) && (tuse < e_tnew);
    assign m_hit  = (src == m_a3) && (tuse < m_tnew);
    // $0 is hard-wired, so it never waits on a producer; tuse 3 means unread
    assign hazard = (src != 5'd0) && (tuse != 2'd3) && (e_hit || m_hit);
endmodule

module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic        D_is_md,
    input  logic [4:0]  E_a3,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_a3,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall_D,
    output logic        flush_E,
    output logic        md_busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt
);
    localparam int NUM_SRC = 2;
    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    logic [NUM_SRC-1:0][4:0] src_reg;
    logic [NUM_SRC-1:0][1:0] src_tuse;
    logic [NUM_SRC-1:0]      src_haz;
    logic [3:0]              md_cnt;
    logic                    md_hazard;

    assign src_reg  = {D_rt, D_rs};
    assign src_tuse = {D_rt_tuse, D_rs_tuse};

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            hazard_src_chk u_chk (
                .src    (src_reg[g]),
                .tuse   (src_tuse[g]),
                .e_a3   (E_a3),
                .e_tnew (E_tnew),
                .m_a3   (M_a3),
                .m_tnew (M_tnew),
                .hazard (src_haz[g])
            );
        end
    endgenerate

    // A new start always reloads, even over a running op
    always_ff @(posedge clk) begin
        if (!reset)
            md_cnt <= 4'd0;
        else if (E_md_start)
            md_cnt <= E_md_div ? DIV_LD : MULT_LD;
        else if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
    end

    assign md_busy   = reset && (E_md_start || (md_cnt != 4'd0));
    assign md_hazard = D_is_md && md_busy;
    assign stall_D   = reset && ((|src_haz) || md_hazard);
    assign flush_E   = stall_D;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] md_stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q    <= 32'd0;
            md_stall_cnt_q <= 32'd0;
        end else begin
            if (stall_D)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (md_hazard)
                md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;
`else
    assign stall_cnt    = 32'h0;
    assign md_stall_cnt = 32'h0;
`endif
endmodule
